serial_fetch_arbiter: RTL and testbench
=======================================

SERIAL_FETCH_ARBITER -- requirements
Module: serial_fetch_arbiter

Interface
REQ-001 Parameter IADDR_W, 8, instruction address width in bits.
REQ-002 Parameter IDATA_W, 16, instruction word width in bits.
REQ-003 Parameter MADDR_W, 9, micro-instruction address width in bits.
REQ-004 Parameter MDATA_W, 24, micro-instruction word width in bits.
REQ-005 Parameter TURN, 1, turnaround cycles between address and data phases; legal range 1..4.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-007 sys_clk  in  1  sole clock; all state changes on the rising edge.
REQ-008 sys_reset  in  1  asynchronous, active-high reset.
REQ-009 i_req  in  1  one-cycle instruction fetch request pulse.
REQ-010 i_addr  in  IADDR_W  instruction address; sampled in the i_req cycle.
REQ-011 i_gnt  out  1  instruction requester owns the serial port.
REQ-012 i_done  out  1  one-cycle pulse; i_data valid.
REQ-013 i_data  out  IDATA_W  last fetched instruction word.
REQ-014 m_req, m_addr (MADDR_W), m_gnt, m_done, m_data (MDATA_W) SHALL mirror REQ-009..013 for the micro-instruction requester.
REQ-015 ser_addr_out  out  1  serial address bit, MSB first.
REQ-016 ser_addr_valid  out  1  ser_addr_out carries a valid bit.
REQ-017 ser_sel  out  1  target memory: 0 = instruction, 1 = micro-instruction.
REQ-018 ser_data_in  in  1  serial data bit from the selected memory, MSB first.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 A req pulse with that requester's pending flag clear SHALL set the flag and capture the address on the same edge.
REQ-021 A req pulse while that requester's flag is already set SHALL be ignored; the captured address is kept.
REQ-022 A req pulse from the current owner during its transfer SHALL set its pending flag; the new fetch is served afterwards.
REQ-023 FSM states: IDLE, ADDR, TURNA, DATA, DONE.
REQ-024 IDLE: with any pending flag set, pick the winner, clear its flag, load its address into the shift register, set ser_sel, and go to ADDR on the next edge.
REQ-025 Arbitration: with one flag set, that requester wins; with both set, the requester not served last wins (round-robin).
REQ-026 ADDR: ser_addr_valid=1 and ser_addr_out=address MSB; shift once per cycle for exactly IADDR_W or MADDR_W cycles, then go to TURNA.
REQ-027 TURNA: ser_addr_valid=0 and ser_addr_out=0 for exactly TURN cycles, then go to DATA.
REQ-028 DATA: on each rising edge, shift ser_data_in into the LSB for exactly IDATA_W or MDATA_W edges (MSB first), then go to DONE.
REQ-029 DONE: hold one cycle; update the owner's data output, pulse the owner's done, record the owner as last served, then go to IDLE.
REQ-030 The owner's gnt SHALL be high from the first ADDR cycle through the DONE cycle inclusive, and low otherwise.
REQ-031 i_data/m_data SHALL hold their value until that requester's next DONE.
REQ-032 ser_sel SHALL be 0 in IDLE.
REQ-033 The bit counter SHALL be wide enough for max(IADDR_W, IDATA_W, MADDR_W, MDATA_W) and SHALL reset to 0 on every state change.
REQ-034 Instruction latency with default parameters: req in cycle 0, pending in cycle 1 (IDLE), ADDR cycles 2-9, TURNA cycle 10, DATA cycles 11-26, i_done in cycle 27.
REQ-035 Back-to-back: after DONE, at least one IDLE cycle before the next ADDR.

Reset
REQ-036 sys_reset SHALL immediately force state IDLE.
REQ-037 sys_reset SHALL immediately clear both pending flags, the shift register, the counter, i_data and m_data.
REQ-038 sys_reset SHALL immediately drive every output to 0.
REQ-039 sys_reset SHALL set last-served to micro, so instruction wins the first tie.
REQ-040 Reset during any transfer SHALL abort it with no done pulse; req pulses while reset is high are dropped.

Verification
REQ-041 i_req with i_addr=0xA5 -> ser_addr_out 1,0,1,0,0,1,0,1 in cycles 2-9, ser_sel=0; memory returns 0x1234 -> i_done in cycle 27, i_data=0x1234.
REQ-042 i_req and m_req in the same cycle after reset -> instruction served first (i_done cycle 27); micro ADDR cycles 29-37, m_done cycle 63.
REQ-043 Both requesters re-pulse req on every done -> grants strictly alternate i, m, i, m.
REQ-044 i_req 0x10 then i_req 0x20 while pending -> only 0x10 is shifted out; no second fetch.
REQ-045 m_req with memory returning 0xABCDEF -> m_data=0xABCDEF, ser_sel=1 through DATA; sys_reset in DATA cycle 5 -> all outputs 0 at once, no m_done.

Source files
------------

// File: rtl/serial_fetch_arbiter.sv
// Round-robin arbiter sharing one bit-serial memory port between an instruction
// fetcher and a micro-instruction fetcher: serial address out, turnaround, serial data in.
module serial_fetch_arbiter #(
    parameter int IADDR_W = 8,
    parameter int IDATA_W = 16,
    parameter int MADDR_W = 9,
    parameter int MDATA_W = 24,
    parameter int TURN    = 1
) (
    input  logic               sys_clk,
    input  logic               sys_reset,

    input  logic               i_req,
    input  logic [IADDR_W-1:0] i_addr,
    output logic               i_gnt,
    output logic               i_done,
    output logic [IDATA_W-1:0] i_data,

    input  logic               m_req,
    input  logic [MADDR_W-1:0] m_addr,
    output logic               m_gnt,
    output logic               m_done,
    output logic [MDATA_W-1:0] m_data,

    output logic               ser_addr_out,
    output logic               ser_addr_valid,
    output logic               ser_sel,
    input  logic               ser_data_in,

    output logic               busy,
    output logic [2:0]         dbg_state_o
);

    localparam int AMAX  = (IADDR_W > MADDR_W) ? IADDR_W : MADDR_W;
    localparam int DMAX  = (IDATA_W > MDATA_W) ? IDATA_W : MDATA_W;
    localparam int SH_W  = (AMAX > DMAX) ? AMAX : DMAX;
    localparam int CNT_W = $clog2(SH_W + 1);

    localparam logic [CNT_W-1:0] I_ALAST   = CNT_W'(IADDR_W - 1);
    localparam logic [CNT_W-1:0] M_ALAST   = CNT_W'(MADDR_W - 1);
    localparam logic [CNT_W-1:0] I_DLAST   = CNT_W'(IDATA_W - 1);
    localparam logic [CNT_W-1:0] M_DLAST   = CNT_W'(MDATA_W - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_TURNA = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               i_pend_q, i_pend_d;
    logic               m_pend_q, m_pend_d;
    logic [IADDR_W-1:0] i_addr_q, i_addr_d;
    logic [MADDR_W-1:0] m_addr_q, m_addr_d;
    logic               owner_q, owner_d;   // 0 = instruction, 1 = micro
    logic               last_q, last_d;     // requester served most recently
    logic [SH_W-1:0]    sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDATA_W-1:0] i_data_q, i_data_d;
    logic [MDATA_W-1:0] m_data_q, m_data_d;
    logic               grant_i, grant_m;
    logic [CNT_W-1:0]   addr_last, data_last;

    assign addr_last = owner_q ? M_ALAST : I_ALAST;
    assign data_last = owner_q ? M_DLAST : I_DLAST;

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q  <= ST_IDLE;
            i_pend_q <= 1'b0;
            m_pend_q <= 1'b0;
            i_addr_q <= '0;
            m_addr_q <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            sh_q     <= '0;
            cnt_q    <= '0;
            i_data_q <= '0;
            m_data_q <= '0;
        end else begin
            state_q  <= state_d;
            i_pend_q <= i_pend_d;
            m_pend_q <= m_pend_d;
            i_addr_q <= i_addr_d;
            m_addr_q <= m_addr_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            i_data_q <= i_data_d;
            m_data_q <= m_data_d;
        end
    end

    // The counter falls back to 0 unless the state holds, so every state change restarts it.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        sh_d     = sh_q;
        cnt_d    = '0;
        i_data_d = i_data_q;
        m_data_d = m_data_q;
        grant_i  = 1'b0;
        grant_m  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_pend_q && (!m_pend_q || last_q)) begin
                    grant_i                  = 1'b1;
                    owner_d                  = 1'b0;
                    sh_d                     = '0;
                    sh_d[SH_W-1 -: IADDR_W]  = i_addr_q;
                    state_d                  = ST_ADDR;
                end else if (m_pend_q) begin
                    grant_m                  = 1'b1;
                    owner_d                  = 1'b1;
                    sh_d                     = '0;
                    sh_d[SH_W-1 -: MADDR_W]  = m_addr_q;
                    state_d                  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                sh_d = {sh_q[SH_W-2:0], 1'b0};
                if (cnt_q == addr_last) state_d = ST_TURNA;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_TURNA: begin
                if (cnt_q == TURN_LAST) state_d = ST_DATA;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_DATA: begin
                sh_d = {sh_q[SH_W-2:0], ser_data_in};
                // The final bit lands straight in the data output so it is valid alongside done.
                if (cnt_q == data_last) begin
                    state_d = ST_DONE;
                    if (owner_q) m_data_d = {sh_q[MDATA_W-2:0], ser_data_in};
                    else         i_data_d = {sh_q[IDATA_W-2:0], ser_data_in};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A request is only taken when its flag is clear; a held flag keeps its captured address.
    always_comb begin
        i_pend_d = i_pend_q;
        i_addr_d = i_addr_q;
        m_pend_d = m_pend_q;
        m_addr_d = m_addr_q;
        if (grant_i) begin
            i_pend_d = 1'b0;
        end else if (i_req && !i_pend_q) begin
            i_pend_d = 1'b1;
            i_addr_d = i_addr;
        end
        if (grant_m) begin
            m_pend_d = 1'b0;
        end else if (m_req && !m_pend_q) begin
            m_pend_d = 1'b1;
            m_addr_d = m_addr;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign i_gnt          = busy && !owner_q;
    assign m_gnt          = busy && owner_q;
    assign i_done         = (state_q == ST_DONE) && !owner_q;
    assign m_done         = (state_q == ST_DONE) && owner_q;
    assign i_data         = i_data_q;
    assign m_data         = m_data_q;
    assign ser_sel        = busy && owner_q;
    assign ser_addr_valid = (state_q == ST_ADDR);
    assign ser_addr_out   = ser_addr_valid && sh_q[SH_W-1];
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_serial_fetch_arbiter.sv
// Bench for serial_fetch_arbiter: a bit-serial memory responder, a done monitor
// with expected-address and grant-order queues, and directed scenarios.
module tb_serial_fetch_arbiter;

    logic        sys_clk;
    logic        sys_reset;
    logic        i_req;
    logic [7:0]  i_addr;
    logic        i_gnt, i_done;
    logic [15:0] i_data;
    logic        m_req;
    logic [8:0]  m_addr;
    logic        m_gnt, m_done;
    logic [23:0] m_data;
    logic        ser_addr_out, ser_addr_valid, ser_sel, ser_data_in;
    logic        busy;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] i_exp_q[$];
    logic [8:0] m_exp_q[$];
    logic       ord_q[$];

    serial_fetch_arbiter dut (
        .sys_clk        (sys_clk),
        .sys_reset      (sys_reset),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_gnt          (i_gnt),
        .i_done         (i_done),
        .i_data         (i_data),
        .m_req          (m_req),
        .m_addr         (m_addr),
        .m_gnt          (m_gnt),
        .m_done         (m_done),
        .m_data         (m_data),
        .ser_addr_out   (ser_addr_out),
        .ser_addr_valid (ser_addr_valid),
        .ser_sel        (ser_sel),
        .ser_data_in    (ser_data_in),
        .busy           (busy),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] iword(input logic [7:0] a);
        if (a == 8'hA5) return 16'h1234;
        return {a ^ 8'h5A, ~a};
    endfunction

    function automatic logic [23:0] mword(input logic [8:0] a);
        if (a == 9'h1AB) return 24'hABCDEF;
        return {a, a[7:0] ^ 8'hC3, 7'h55};
    endfunction

    // ---------------- serial memory responder ----------------
    logic [31:0] r_abuf;
    logic [23:0] r_word;
    logic        r_sel;
    int          r_n, r_dw;

    initial begin
        ser_data_in = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!sys_reset && ser_addr_valid) begin
                r_sel  = ser_sel;
                r_abuf = '0;
                r_n    = 0;
                while (ser_addr_valid && !sys_reset && r_n < 32) begin
                    r_abuf = (r_abuf << 1) | {31'd0, ser_addr_out};
                    r_n++;
                    @(negedge sys_clk);
                end
                if (!sys_reset) begin
                    check("turn_addr_out", {31'd0, ser_addr_out}, 32'd0);
                    check("turn_sel", {31'd0, ser_sel}, {31'd0, r_sel});
                    if (r_sel) begin
                        check("m_addr_len", r_n, 9);
                        check("m_addr_bits", r_abuf, (m_exp_q.size() > 0) ? {23'd0, m_exp_q[0]} : 32'hDEAD);
                        r_word = mword(r_abuf[8:0]);
                        r_dw   = 24;
                    end else begin
                        check("i_addr_len", r_n, 8);
                        check("i_addr_bits", r_abuf, (i_exp_q.size() > 0) ? {24'd0, i_exp_q[0]} : 32'hDEAD);
                        r_word = {8'd0, iword(r_abuf[7:0])};
                        r_dw   = 16;
                    end
                    repeat (1) @(negedge sys_clk);
                    for (int k = 0; k < r_dw; k++) begin
                        if (sys_reset) break;
                        ser_data_in = r_word[r_dw-1-k];
                        @(negedge sys_clk);
                    end
                    ser_data_in = 1'b0;
                end
            end
        end
    end

    // ---------------- done monitor / scoreboard ----------------
    always @(negedge sys_clk) begin
        logic [7:0] ia;
        logic [8:0] ma;
        if (!sys_reset) begin
            if (i_done) begin
                if (i_exp_q.size() == 0) check("i_done_unexpected", 32'd1, 32'd0);
                else begin
                    ia = i_exp_q.pop_front();
                    check("i_data", {16'd0, i_data}, {16'd0, iword(ia)});
                    check("i_gnt_at_done", {31'd0, i_gnt}, 32'd1);
                end
                if (ord_q.size() == 0) check("order_unexpected", 32'd1, 32'd0);
                else check("grant_order", 32'd0, {31'd0, ord_q.pop_front()});
            end
            if (m_done) begin
                if (m_exp_q.size() == 0) check("m_done_unexpected", 32'd1, 32'd0);
                else begin
                    ma = m_exp_q.pop_front();
                    check("m_data", {8'd0, m_data}, {8'd0, mword(ma)});
                    check("m_gnt_at_done", {31'd0, m_gnt}, 32'd1);
                end
                if (ord_q.size() == 0) check("order_unexpected", 32'd1, 32'd0);
                else check("grant_order", 32'd1, {31'd0, ord_q.pop_front()});
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_done(input logic sel, input int limit, output int cyc);
        cyc = 0;
        while (!(sel ? m_done : i_done) && cyc < limit) begin
            @(negedge sys_clk);
            cyc++;
        end
        if (cyc >= limit) check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_gnt"},   {30'd0, i_gnt, m_gnt}, 32'd0);
        check({tag, "_done"},  {30'd0, i_done, m_done}, 32'd0);
        check({tag, "_ser"},   {29'd0, ser_addr_out, ser_addr_valid, ser_sel}, 32'd0);
        check({tag, "_data"},  {8'd0, m_data} | {16'd0, i_data}, 32'd0);
        check({tag, "_state"}, {29'd0, dbg_state}, 32'd0);
    endtask

    // ---------------- scenarios ----------------
    int c, c2, i_sent, m_sent;

    initial begin
        sys_reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        m_req = 1'b0; m_addr = '0;
        repeat (2) @(negedge sys_clk);
        i_req = 1'b1; i_addr = 8'h77;          // dropped while in reset
        @(negedge sys_clk);
        i_req = 1'b0;
        check_all_zero("reset");
        sys_reset = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("post_reset_idle", {29'd0, dbg_state}, 32'd0);

        // Single instruction fetch and its cycle-accurate latency.
        i_req = 1'b1; i_addr = 8'hA5;
        i_exp_q.push_back(8'hA5); ord_q.push_back(1'b0);
        @(negedge sys_clk);
        i_req = 1'b0;
        check("c1_busy", {31'd0, busy}, 32'd0);
        check("c1_i_gnt", {31'd0, i_gnt}, 32'd0);
        @(negedge sys_clk);
        check("c2_i_gnt", {31'd0, i_gnt}, 32'd1);
        check("c2_addr_valid", {31'd0, ser_addr_valid}, 32'd1);
        check("c2_addr_msb", {31'd0, ser_addr_out}, 32'd1);
        check("c2_sel", {31'd0, ser_sel}, 32'd0);
        wait_done(1'b0, 100, c);
        check("i_done_cycle", 2 + c, 27);
        @(negedge sys_clk);
        check("c28_idle", {29'd0, dbg_state}, 32'd0);
        check("c28_i_done_low", {31'd0, i_done}, 32'd0);
        check("i_data_hold", {16'd0, i_data}, 32'h1234);
        repeat (4) @(negedge sys_clk);

        // Simultaneous requests after reset: instruction wins the first tie.
        sys_reset = 1'b1;
        @(negedge sys_clk);
        sys_reset = 1'b0;
        @(negedge sys_clk);
        i_req = 1'b1; i_addr = 8'h3C;
        m_req = 1'b1; m_addr = 9'h155;
        i_exp_q.push_back(8'h3C); m_exp_q.push_back(9'h155);
        ord_q.push_back(1'b0); ord_q.push_back(1'b1);
        @(negedge sys_clk);
        i_req = 1'b0; m_req = 1'b0;
        wait_done(1'b0, 100, c);
        check("tie_i_done_cycle", 1 + c, 27);
        wait_done(1'b1, 100, c2);
        check("tie_m_done_cycle", 1 + c + c2, 63);
        check("i_data_held_over_m", {16'd0, i_data}, {16'd0, iword(8'h3C)});
        repeat (4) @(negedge sys_clk);

        // Both re-request on every done: grants must alternate.
        i_req = 1'b1; i_addr = 8'($urandom_range(0, 255));
        m_req = 1'b1; m_addr = 9'($urandom_range(0, 511));
        i_exp_q.push_back(i_addr); m_exp_q.push_back(m_addr);
        for (int k = 0; k < 3; k++) begin
            ord_q.push_back(1'b0);
            ord_q.push_back(1'b1);
        end
        i_sent = 1; m_sent = 1; c = 0;
        @(negedge sys_clk);
        while (ord_q.size() > 0 && c < 800) begin
            i_req = 1'b0; m_req = 1'b0;
            if (i_done && i_sent < 3) begin
                i_req = 1'b1; i_addr = 8'($urandom_range(0, 255));
                i_exp_q.push_back(i_addr); i_sent++;
            end
            if (m_done && m_sent < 3) begin
                m_req = 1'b1; m_addr = 9'($urandom_range(0, 511));
                m_exp_q.push_back(m_addr); m_sent++;
            end
            @(negedge sys_clk);
            c++;
        end
        i_req = 1'b0; m_req = 1'b0;
        check("alt_complete", ord_q.size(), 0);
        repeat (5) @(negedge sys_clk);

        // Second request while pending is ignored.
        i_req = 1'b1; i_addr = 8'h10;
        i_exp_q.push_back(8'h10); ord_q.push_back(1'b0);
        @(negedge sys_clk);
        i_addr = 8'h20;
        @(negedge sys_clk);
        i_req = 1'b0;
        repeat (70) @(negedge sys_clk);
        check("ignore_q_empty", i_exp_q.size(), 0);
        check("ignore_idle", {31'd0, busy}, 32'd0);

        // Owner re-request during its own transfer is served afterwards.
        i_req = 1'b1; i_addr = 8'h33;
        i_exp_q.push_back(8'h33); ord_q.push_back(1'b0);
        @(negedge sys_clk);
        i_req = 1'b0;
        repeat (4) @(negedge sys_clk);
        i_req = 1'b1; i_addr = 8'h44;
        i_exp_q.push_back(8'h44); ord_q.push_back(1'b0);
        @(negedge sys_clk);
        i_req = 1'b0;
        repeat (80) @(negedge sys_clk);
        check("rereq_q_empty", i_exp_q.size() + ord_q.size(), 0);

        // Micro fetch with select check during DATA.
        m_req = 1'b1; m_addr = 9'h1AB;
        m_exp_q.push_back(9'h1AB); ord_q.push_back(1'b1);
        @(negedge sys_clk);
        m_req = 1'b0;
        repeat (19) @(negedge sys_clk);
        check("m_data_state", {29'd0, dbg_state}, 32'd3);
        check("m_data_sel", {31'd0, ser_sel}, 32'd1);
        check("m_data_gnt", {30'd0, i_gnt, m_gnt}, 32'd1);
        wait_done(1'b1, 100, c);
        check("m_done_cycle", 20 + c, 36);
        repeat (4) @(negedge sys_clk);

        // Reset in DATA cycle 5 aborts without done.
        m_req = 1'b1; m_addr = 9'h0F0;
        m_exp_q.push_back(9'h0F0); ord_q.push_back(1'b1);
        @(negedge sys_clk);
        m_req = 1'b0;
        repeat (15) @(negedge sys_clk);
        check("abort_in_data", {29'd0, dbg_state}, 32'd3);
        #2;
        sys_reset = 1'b1;
        #1;
        check_all_zero("abort");
        i_exp_q.delete(); m_exp_q.delete(); ord_q.delete();
        @(negedge sys_clk);
        m_req = 1'b1; m_addr = 9'h1AB;          // dropped while in reset
        @(negedge sys_clk);
        m_req = 1'b0;
        sys_reset = 1'b0;
        repeat (50) @(negedge sys_clk);
        check("abort_stays_idle", {31'd0, busy}, 32'd0);
        check("abort_m_data", {8'd0, m_data}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
